// File: rtl/my_write_scoreboard_pkg.sv
// Shared constants and types for the write scoreboard that tracks in-flight
// register writes for RAW hazard detection.
package my_write_scoreboard_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int CNT_W    = 2;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
  localparam int REG_ZERO = 0;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  localparam reg_addr_t REG_ZERO_ADDR = reg_addr_t'(REG_ZERO);
  localparam cnt_t      CNT_FULL      = cnt_t'(CNT_MAX);

  // True when addr selects a tracked register equal to target.
  function automatic logic addr_hit(input reg_addr_t addr, input reg_addr_t target);
    return (addr == target) && (addr != REG_ZERO_ADDR);
  endfunction

endpackage

// File: rtl/my_write_scoreboard_entry.sv
// One scoreboard slot: a saturating-by-construction up/down counter of
// outstanding writes to a single architectural register.
module my_scoreboard_entry
  import my_write_scoreboard_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic nonzero,
  output logic full,
  output logic underflow
);

  cnt_t count;

  // Simultaneous inc and dec cancel; clr wins over both.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !dec && (count != CNT_FULL)) begin
      count <= count + cnt_t'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - cnt_t'(1);
    end
  end

  assign nonzero   = (count != '0);
  assign full      = (count == CNT_FULL);
  assign underflow = dec && !inc && !clr && (count == '0);

endmodule

// File: rtl/my_write_scoreboard.sv
// Write scoreboard: counts outstanding writes per register, reports RAW
// hazards on two source ports and back-pressures issue when a counter is full.
module my_write_scoreboard
  import my_write_scoreboard_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              issue_ready,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic              flush,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic              stall,
  output logic              any_pending,
  output logic              underflow_err
);

  logic [NUM_REGS-1:1] nonzero_vec;
  logic [NUM_REGS-1:1] full_vec;
  logic [NUM_REGS-1:1] underflow_vec;
  logic [NUM_REGS-1:0] nonzero_map;
  logic [NUM_REGS-1:0] full_map;
  logic                wb_same_rd;
  logic                issue_accept;

  // Register 0 is untracked, so its slot in the lookup maps is tied low.
  assign nonzero_map = {nonzero_vec, 1'b0};
  assign full_map    = {full_vec, 1'b0};

  // A full counter can still take an issue when the same register retires now.
  always_comb begin
    wb_same_rd   = wb_valid && (wb_rd == issue_rd);
    issue_ready  = !((issue_rd != REG_ZERO_ADDR) && full_map[issue_rd] && !wb_same_rd);
    issue_accept = issue_valid && issue_ready && (issue_rd != REG_ZERO_ADDR);
  end

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    localparam reg_addr_t ENTRY_ADDR = reg_addr_t'(r);

    my_scoreboard_entry u_entry (
      .clock     (clock),
      .reset     (reset),
      .inc       (issue_accept && (issue_rd == ENTRY_ADDR)),
      .dec       (wb_valid && addr_hit(wb_rd, ENTRY_ADDR)),
      .clr       (flush),
      .nonzero   (nonzero_vec[r]),
      .full      (full_vec[r]),
      .underflow (underflow_vec[r])
    );
  end

  // Hazards look only at registered counts; a retiring write still stalls.
  always_comb begin
    hazard_a    = (src_a != REG_ZERO_ADDR) && nonzero_map[src_a];
    hazard_b    = (src_b != REG_ZERO_ADDR) && nonzero_map[src_b];
    stall       = hazard_a || hazard_b || (issue_valid && !issue_ready);
    any_pending = |nonzero_vec;
  end

  // Sticky error; flush deliberately leaves it alone.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      underflow_err <= 1'b0;
    end else if (|underflow_vec) begin
      underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_my_write_scoreboard.sv
// Self-checking bench for my_write_scoreboard: directed scenarios plus random
// traffic compared every cycle against a per-register count model.
module tb_my_write_scoreboard;
  import my_write_scoreboard_pkg::*;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              issue_valid = 1'b0;
  logic [ADDR_W-1:0] issue_rd = '0;
  logic              wb_valid = 1'b0;
  logic [ADDR_W-1:0] wb_rd = '0;
  logic              flush = 1'b0;
  logic [ADDR_W-1:0] src_a = '0;
  logic [ADDR_W-1:0] src_b = '0;
  logic              issue_ready;
  logic              hazard_a;
  logic              hazard_b;
  logic              stall;
  logic              any_pending;
  logic              underflow_err;

  int n_cmp  = 0;
  int n_fail = 0;

  int model_cnt [NUM_REGS];
  bit model_err = 1'b0;

  always #5 clock = ~clock;

  my_write_scoreboard dut (
    .clock         (clock),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .issue_ready   (issue_ready),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .flush         (flush),
    .src_a         (src_a),
    .src_b         (src_b),
    .hazard_a      (hazard_a),
    .hazard_b      (hazard_b),
    .stall         (stall),
    .any_pending   (any_pending),
    .underflow_err (underflow_err)
  );

  initial begin
    foreach (model_cnt[r]) model_cnt[r] = 0;
  end

  task automatic check_output(input string name, input logic actual, input logic expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic check_int(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit model_ready();
    if (issue_rd == '0) return 1'b1;
    if (model_cnt[issue_rd] < CNT_MAX) return 1'b1;
    return wb_valid && (wb_rd == issue_rd);
  endfunction

  function automatic bit model_hazard(input logic [ADDR_W-1:0] src);
    return (src != '0) && (model_cnt[src] != 0);
  endfunction

  function automatic bit model_any();
    for (int r = 1; r < NUM_REGS; r++) if (model_cnt[r] != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Reference model: counts outstanding writes per register.
  always @(posedge clock or posedge reset) begin
    bit acc;
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) model_cnt[r] = 0;
      model_err = 1'b0;
    end else if (flush) begin
      for (int r = 0; r < NUM_REGS; r++) model_cnt[r] = 0;
    end else begin
      acc = issue_valid && model_ready() && (issue_rd != '0);
      for (int r = 1; r < NUM_REGS; r++) begin
        bit is_issue;
        bit is_wb;
        is_issue = acc && (int'(issue_rd) == r);
        is_wb    = wb_valid && (int'(wb_rd) == r);
        if (is_issue && !is_wb) model_cnt[r] = model_cnt[r] + 1;
        else if (is_wb && !is_issue) begin
          if (model_cnt[r] > 0) model_cnt[r] = model_cnt[r] - 1;
          else model_err = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clock) begin
    #2;
    check_output("hazard_a", hazard_a, model_hazard(src_a));
    check_output("hazard_b", hazard_b, model_hazard(src_b));
    check_output("issue_ready", issue_ready, model_ready());
    check_output("stall", stall,
                 model_hazard(src_a) || model_hazard(src_b) || (issue_valid && !model_ready()));
    check_output("any_pending", any_pending, model_any());
    check_output("underflow_err", underflow_err, model_err);
  end

  task automatic apply_stimulus(input bit iv, input int ird, input bit wv, input int wrd,
                                input bit fl, input int sa, input int sb);
    @(negedge clock);
    issue_valid = iv;
    issue_rd    = ird[ADDR_W-1:0];
    wb_valid    = wv;
    wb_rd       = wrd[ADDR_W-1:0];
    flush       = fl;
    src_a       = sa[ADDR_W-1:0];
    src_b       = sb[ADDR_W-1:0];
    #3;
  endtask

  task automatic mid_cycle_reset();
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check_output("rst_hazard_a", hazard_a, 1'b0);
    check_output("rst_any_pending", any_pending, 1'b0);
    check_output("rst_underflow", underflow_err, 1'b0);
    check_output("rst_issue_ready", issue_ready, 1'b1);
    #1 reset = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;

    // Idle after reset
    apply_stimulus(0, 0, 0, 0, 0, 5, 0);
    check_output("idle_hazard_a", hazard_a, 1'b0);
    check_output("idle_hazard_b", hazard_b, 1'b0);
    check_output("idle_stall", stall, 1'b0);
    check_output("idle_ready", issue_ready, 1'b1);
    check_output("idle_pending", any_pending, 1'b0);

    // Issue/retire latency on r5
    apply_stimulus(1, 5, 0, 0, 0, 5, 0);
    check_output("r5_issue_cycle", hazard_a, 1'b0);
    apply_stimulus(0, 0, 0, 0, 0, 5, 0);
    check_output("r5_after_issue", hazard_a, 1'b1);
    check_output("r5_pending", any_pending, 1'b1);
    apply_stimulus(0, 0, 0, 0, 0, 5, 0);
    apply_stimulus(0, 0, 1, 5, 0, 5, 0);
    check_output("r5_retire_cycle", hazard_a, 1'b1);
    apply_stimulus(0, 0, 0, 0, 0, 5, 0);
    check_output("r5_after_retire", hazard_a, 1'b0);
    check_output("r5_no_pending", any_pending, 1'b0);

    // Saturation on r7
    repeat (3) apply_stimulus(1, 7, 0, 0, 0, 0, 0);
    apply_stimulus(1, 7, 0, 0, 0, 0, 0);
    check_output("r7_full_ready", issue_ready, 1'b0);
    check_output("r7_full_stall", stall, 1'b1);
    check_int("model_cnt7_full", model_cnt[7], 3);
    apply_stimulus(1, 7, 1, 7, 0, 0, 0);
    check_output("r7_wb_ready", issue_ready, 1'b1);
    check_output("r7_wb_stall", stall, 1'b0);
    apply_stimulus(1, 7, 0, 0, 0, 0, 0);
    check_output("r7_still_full", issue_ready, 1'b0);
    check_int("model_cnt7_kept", model_cnt[7], 3);
    repeat (3) apply_stimulus(0, 0, 1, 7, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 7, 0);
    check_output("r7_drained", hazard_a, 1'b0);

    // Same-cycle issue and writeback on r9, then issue to r0
    apply_stimulus(1, 9, 0, 0, 0, 0, 0);
    apply_stimulus(1, 9, 1, 9, 0, 9, 0);
    check_output("r9_both_cycle", hazard_a, 1'b1);
    apply_stimulus(0, 0, 0, 0, 0, 9, 0);
    check_output("r9_persists", hazard_a, 1'b1);
    check_int("model_cnt9", model_cnt[9], 1);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0);
    check_output("r0_hazard", hazard_a, 1'b0);
    check_output("r0_ready", issue_ready, 1'b1);
    apply_stimulus(0, 0, 1, 9, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check_output("r0_no_effect", any_pending, 1'b0);

    // Underflow on r12 is sticky through flush
    apply_stimulus(0, 0, 1, 12, 0, 0, 0);
    check_output("uf_same_cycle", underflow_err, 1'b0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check_output("uf_set", underflow_err, 1'b1);
    apply_stimulus(0, 0, 0, 0, 1, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check_output("uf_after_flush", underflow_err, 1'b1);

    // Flush overrides a simultaneous issue
    apply_stimulus(1, 3, 0, 0, 0, 0, 0);
    apply_stimulus(1, 4, 0, 0, 0, 0, 0);
    apply_stimulus(1, 6, 0, 0, 1, 3, 4);
    check_output("fl_hazard_a", hazard_a, 1'b1);
    check_output("fl_hazard_b", hazard_b, 1'b1);
    apply_stimulus(0, 0, 0, 0, 0, 3, 6);
    check_output("fl_cleared_a", hazard_a, 1'b0);
    check_output("fl_cleared_b", hazard_b, 1'b0);
    check_output("fl_no_pending", any_pending, 1'b0);

    // Asynchronous reset between edges
    apply_stimulus(1, 5, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 5, 0);
    check_output("pre_rst_hazard", hazard_a, 1'b1);
    mid_cycle_reset();

    // Random traffic on a small register window to force collisions
    for (int i = 0; i < 1500; i++) begin
      bit fl;
      bit wv;
      fl = ($urandom_range(0, 39) == 0);
      wv = fl ? 1'b0 : ($urandom_range(0, 9) < 4);
      apply_stimulus($urandom_range(0, 1), $urandom_range(0, 7), wv, $urandom_range(0, 7),
                     fl, $urandom_range(0, 7), $urandom_range(0, 7));
      if ((i % 400) == 399) mid_cycle_reset();
    end

    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
